pulse_to_led_blinker: RTL and testbench
=======================================

Name: pulse_to_led_blinker

Overview:
Converts single-cycle internal event pulses, such as debounced button pulses or filter-status events, into human-visible blinks on an active-low board LED. Each accepted pulse produces exactly one fixed-length blink followed by a fixed dark gap. Pulses that arrive while a blink is in progress are queued in a saturating counter and replayed in order. A sticky flag reports any lost events. The block sits between the control logic and the FPGA LED pins.

Parameters:
ON_CYCLES, 12500000, LED-on duration in clk50 cycles (250 ms at 50 MHz); must be >= 1
OFF_CYCLES, 12500000, dark gap after each blink in clk50 cycles; must be >= 1
QUEUE_MAX, 15, maximum number of queued (not yet started) blinks
Q_W, 4, width of the pending counter; must hold QUEUE_MAX
CNT_W, 32, width of the internal duration counter; must hold max(ON_CYCLES, OFF_CYCLES)

Ports:
clk50  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
pulse  in  1  event request, active-high; every cycle it is high counts as one event
led_n  out  1  LED drive, active-low (0 = lit)
busy  out  1  high whenever state != IDLE
pending  out  Q_W  number of queued blinks not yet started
overflow  out  1  sticky flag: an event was dropped because the queue was full

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - rst is synchronous, active-high, and overrides everything.
  - After the reset edge: state=IDLE, led_n=1, busy=0, pending=0, overflow=0, duration counter=0.
  - Reset mid-operation aborts the current blink and flushes the queue. The LED is dark on the cycle after the reset edge.
- States: IDLE, ON, OFF.
- IDLE:
  - led_n=1, busy=0.
  - pulse=1 at edge k: state becomes ON and led_n=0 from edge k (one-cycle latency from pulse to LED).
  - pending is unchanged by this pulse.
- ON:
  - led_n=0 for exactly ON_CYCLES cycles.
  - Then state becomes OFF and led_n=1.
- OFF:
  - led_n=1 for exactly OFF_CYCLES cycles.
  - At the end of OFF, if pending>0 or pulse=1 in that last cycle: go directly to ON with no IDLE cycle.
  - At the end of OFF otherwise: go to IDLE.
  - Total busy time per blink is exactly ON_CYCLES+OFF_CYCLES cycles.
- Queue:
  - pulse=1 while in ON or OFF increments pending, except in the last OFF cycle (see simultaneous events below).
  - If pending==QUEUE_MAX when such a pulse arrives, the event is dropped, pending stays at QUEUE_MAX, and overflow is set.
  - overflow is cleared only by rst.
- Dequeue:
  - At the end of OFF with pending>0, pending decrements by 1 and a new ON starts.
- Simultaneous events in the last OFF cycle:
  - pulse=1 and pending>0: the dequeue and the enqueue cancel, pending is unchanged, and the next state is ON.
  - pulse=1 and pending==0: the pulse starts the next blink directly, pending stays 0, and the next state is ON.
- Counter:
  - A single down-counter of width CNT_W.
  - It is loaded with ON_CYCLES-1 on entry to ON and with OFF_CYCLES-1 on entry to OFF.
  - A phase ends when the counter equals 0.
  - The counter never wraps.
- Held-high pulse:
  - Each high cycle is a separate event.
  - Upstream must deliver single-cycle pulses; the block does not edge-detect.

Test Plan:
All scenarios use simulation parameters ON_CYCLES=4, OFF_CYCLES=3, QUEUE_MAX=3, Q_W=2.
1. Reset: assert rst for 2 cycles with pulse=1 -> led_n=1, busy=0, pending=0, overflow=0 throughout and after release; no blink starts.
2. Single pulse at edge k -> led_n=0 for edges k..k+3 and 1 from k+4; busy=1 for edges k..k+6 and 0 at k+7; pending stays 0.
3. Pulses at k, k+1, k+2 -> pending reaches 2 at k+2; three blinks, each with 4 low and 3 high cycles; pending drops to 1 at k+7 and to 0 at k+14; busy falls at k+21; overflow=0.
4. Pulses on 5 consecutive cycles from IDLE -> pending saturates at 3; overflow=1 from the 5th pulse onward; exactly 4 blinks are emitted; overflow remains 1 afterwards until rst.
5. Single pulse at k, second pulse at k+6 (last OFF cycle, pending=0) -> second ON begins at k+7 with no IDLE cycle; pending stays 0; busy continuously high until k+14.
6. rst asserted at k+2 during ON with pending=2 -> led_n=1, busy=0, pending=0 after that edge; a new pulse afterwards yields a normal single 4-cycle blink.

Source files
------------

// File: rtl/pulse_to_led_blinker_if.sv
// Event-pulse input and LED/status outputs of the pulse-to-LED blinker.
// The control side holds the master modport and the blinker holds the slave modport.
interface pulse_to_led_blinker_if #(
  parameter int Q_W = 4
);
  logic           pulse;
  logic           led_n;
  logic           busy;
  logic [Q_W-1:0] pending;
  logic           overflow;

  modport master (
    output pulse,
    input  led_n,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse,
    output led_n,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_to_led_blinker.sv
// Turns single-cycle event pulses into fixed-length blinks on an active-low LED.
// Events that arrive during a blink are counted in a saturating queue and replayed in order.
module pulse_to_led_blinker #(
  parameter int ON_CYCLES  = 12500000,
  parameter int OFF_CYCLES = 12500000,
  parameter int QUEUE_MAX  = 15,
  parameter int Q_W        = 4,
  parameter int CNT_W      = 32
) (
  input logic                   clk50,
  input logic                   rst,
  pulse_to_led_blinker_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [Q_W-1:0]   Q_MAX    = Q_W'(QUEUE_MAX);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [Q_W-1:0]   pending_q, pending_nx;
  logic             overflow_q, overflow_nx;
  logic             led_n_q, busy_q;
  logic             phase_done;

  assign phase_done = (cnt == '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves it
    // unassigned; an unassigned path in combinational logic infers a latch.
    state_nx    = state;
    cnt_nx      = cnt;
    pending_nx  = pending_q;
    overflow_nx = overflow_q;

    case (state)
      ST_IDLE: begin
        if (bus.pulse) begin
          state_nx = ST_ON;
          cnt_nx   = ON_LOAD;
        end
      end

      ST_ON: begin
        if (bus.pulse) begin
          if (pending_q == Q_MAX) overflow_nx = 1'b1;
          else                    pending_nx  = pending_q + Q_W'(1);
        end
        if (phase_done) begin
          state_nx = ST_OFF;
          cnt_nx   = OFF_LOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      ST_OFF: begin
        if (phase_done) begin
          // A pulse in the last dark cycle either starts the next blink itself or
          // cancels against the dequeue, so pending is untouched in that case.
          if (bus.pulse || pending_q != '0) begin
            state_nx = ST_ON;
            cnt_nx   = ON_LOAD;
            if (!bus.pulse) pending_nx = pending_q - Q_W'(1);
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
          if (bus.pulse) begin
            if (pending_q == Q_MAX) overflow_nx = 1'b1;
            else                    pending_nx  = pending_q + Q_W'(1);
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_n_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pending_q  <= pending_nx;
      overflow_q <= overflow_nx;
      led_n_q    <= (state_nx != ST_ON);
      busy_q     <= (state_nx != ST_IDLE);
    end
  end

  assign bus.led_n    = led_n_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pulse_to_led_blinker.sv
// Directed bench for pulse_to_led_blinker: a reference model pushes expected outputs
// into a scoreboard each cycle, and they are popped and compared one cycle later.
module tb_pulse_to_led_blinker;
  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int QMAX  = 3;
  localparam int QW    = 2;

  typedef struct {
    logic          led_n;
    logic          busy;
    logic [QW-1:0] pending;
    logic          overflow;
  } exp_t;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;

  pulse_to_led_blinker_if #(.Q_W(QW)) bus ();

  pulse_to_led_blinker #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .QUEUE_MAX (QMAX),
    .Q_W       (QW),
    .CNT_W     (32)
  ) dut (
    .clk50(clk50),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk50 = ~clk50;

  int   errors = 0;
  int   checks = 0;
  int   blinks = 0;
  logic prev_led_n = 1'b1;
  exp_t sb[$];

  // Reference model: 0 = idle, 1 = lit, 2 = dark gap; elapsed counts cycles spent in the phase.
  int m_state   = 0;
  int m_elapsed = 0;
  int m_pend    = 0;
  bit m_ovf     = 1'b0;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void m_enqueue();
    if (m_pend == QMAX) m_ovf = 1'b1;
    else                m_pend++;
  endfunction

  function automatic void model_step(input bit p, input bit r);
    if (r) begin
      m_state = 0; m_elapsed = 0; m_pend = 0; m_ovf = 1'b0;
    end else begin
      case (m_state)
        0: if (p) begin m_state = 1; m_elapsed = 0; end
        1: begin
          if (p) m_enqueue();
          if (m_elapsed == ON_C - 1) begin m_state = 2; m_elapsed = 0; end
          else m_elapsed++;
        end
        default: begin
          if (m_elapsed == OFF_C - 1) begin
            m_elapsed = 0;
            if (p)               m_state = 1;
            else if (m_pend > 0) begin m_pend--; m_state = 1; end
            else                 m_state = 0;
          end else begin
            if (p) m_enqueue();
            m_elapsed++;
          end
        end
      endcase
    end
  endfunction

  // One clock cycle: drive on the falling edge, compare 1 ns after the rising edge.
  task automatic tick(input bit p, input bit r);
    exp_t e;
    exp_t got;
    @(negedge clk50);
    bus.pulse = p;
    rst       = r;
    model_step(p, r);
    e.led_n    = (m_state != 1);
    e.busy     = (m_state != 0);
    e.pending  = QW'(m_pend);
    e.overflow = m_ovf;
    sb.push_back(e);
    @(posedge clk50);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("led_n",    int'(bus.led_n),    int'(got.led_n));
      check("busy",     int'(bus.busy),     int'(got.busy));
      check("pending",  int'(bus.pending),  int'(got.pending));
      check("overflow", int'(bus.overflow), int'(got.overflow));
    end
    if (prev_led_n === 1'b1 && bus.led_n === 1'b0) blinks++;
    prev_led_n = bus.led_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  int b0;

  initial begin
    bus.pulse = 1'b0;

    // Reset held for two cycles with pulse high: nothing may start.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    idle(2);
    check("t1_busy", int'(bus.busy), 0);
    check("t1_blinks", blinks, 0);

    // Single pulse: 4 lit, 3 dark, busy drops after 7 cycles.
    b0 = blinks;
    tick(1'b1, 1'b0);
    check("t2_led_on_k", int'(bus.led_n), 0);
    idle(3);
    check("t2_led_on_k3", int'(bus.led_n), 0);
    idle(1);
    check("t2_led_off_k4", int'(bus.led_n), 1);
    idle(2);
    check("t2_busy_k6", int'(bus.busy), 1);
    idle(1);
    check("t2_busy_k7", int'(bus.busy), 0);
    check("t2_blinks", blinks - b0, 1);
    idle(2);

    // Three back-to-back pulses: two queued, three blinks, busy falls at k+21.
    b0 = blinks;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("t3_pending_k2", int'(bus.pending), 2);
    idle(4);
    check("t3_pending_k6", int'(bus.pending), 2);
    idle(1);
    check("t3_pending_k7", int'(bus.pending), 1);
    idle(7);
    check("t3_pending_k14", int'(bus.pending), 0);
    idle(6);
    check("t3_busy_k20", int'(bus.busy), 1);
    idle(1);
    check("t3_busy_k21", int'(bus.busy), 0);
    check("t3_blinks", blinks - b0, 3);
    check("t3_overflow", int'(bus.overflow), 0);
    idle(2);

    // Five consecutive pulses: queue saturates at 3, one event dropped, four blinks.
    b0 = blinks;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    check("t4_overflow_before", int'(bus.overflow), 0);
    tick(1'b1, 1'b0);
    check("t4_pending_sat", int'(bus.pending), QMAX);
    check("t4_overflow_set", int'(bus.overflow), 1);
    idle(30);
    check("t4_blinks", blinks - b0, 4);
    check("t4_busy_end", int'(bus.busy), 0);
    check("t4_overflow_sticky", int'(bus.overflow), 1);
    tick(1'b0, 1'b1);
    check("t4_overflow_clr", int'(bus.overflow), 0);
    idle(1);

    // Pulse in the last dark cycle chains straight into the next blink.
    b0 = blinks;
    tick(1'b1, 1'b0);
    idle(6);
    tick(1'b1, 1'b0);
    check("t5_led_k7", int'(bus.led_n), 0);
    check("t5_busy_k7", int'(bus.busy), 1);
    check("t5_pending_k7", int'(bus.pending), 0);
    idle(6);
    check("t5_busy_k13", int'(bus.busy), 1);
    idle(1);
    check("t5_busy_k14", int'(bus.busy), 0);
    check("t5_blinks", blinks - b0, 2);
    idle(2);

    // Reset mid-blink with two queued events, then a clean single blink.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("t6_pending_pre", int'(bus.pending), 2);
    tick(1'b0, 1'b1);
    check("t6_led_rst", int'(bus.led_n), 1);
    check("t6_busy_rst", int'(bus.busy), 0);
    check("t6_pending_rst", int'(bus.pending), 0);
    idle(2);
    check("t6_no_replay", int'(bus.busy), 0);
    b0 = blinks;
    tick(1'b1, 1'b0);
    idle(10);
    check("t6_blinks", blinks - b0, 1);
    check("t6_busy_end", int'(bus.busy), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
